// File: rtl/seven_seg_capture_if.sv
// Bus bundle for the 7-segment capture block: multiplexed segment bus in,
// decoded digit state out.
interface seven_seg_capture_if;
  logic [6:0] seg;
  logic       dig_sel;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] valid;
  logic [1:0] err;
  logic       upd;
  logic       upd_sel;

  // Display-side source drives the bus and observes the decoded result.
  modport master (
    output seg, dig_sel,
    input  digit0, digit1, valid, err, upd, upd_sel
  );

  // Capture block consumes the bus and reports decoded digits.
  modport slave (
    input  seg, dig_sel,
    output digit0, digit1, valid, err, upd, upd_sel
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Samples a two-digit multiplexed active-high 7-segment bus, waits for each
// pattern to be stable for STABLE_CYCLES synchronized samples, and decodes it
// back to a hex nibble per digit, flagging illegal patterns.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  seven_seg_capture_if.slave  bus
);

  localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [7:0]    sync1_q, sync2_q, s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match;
  logic          capture;
  logic [4:0]    dec;
  logic          cap_sel;
  logic [6:0]    cap_seg;

  logic [3:0] digit0_q, digit0_d;
  logic [3:0] digit1_q, digit1_d;
  logic [1:0] valid_q, valid_d;
  logic [1:0] err_q, err_d;
  logic       upd_q, upd_d;
  logic       upd_sel_q, upd_sel_d;

  // Returns {legal, nibble}; legal=0 for any pattern outside the hex table.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = {1'b1, 4'h0};
      7'b0000110: decode = {1'b1, 4'h1};
      7'b1011011: decode = {1'b1, 4'h2};
      7'b1001111: decode = {1'b1, 4'h3};
      7'b1100110: decode = {1'b1, 4'h4};
      7'b1101101: decode = {1'b1, 4'h5};
      7'b1111101: decode = {1'b1, 4'h6};
      7'b0000111: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1101111: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b1111100: decode = {1'b1, 4'hB};
      7'b0111001: decode = {1'b1, 4'hC};
      7'b1011110: decode = {1'b1, 4'hD};
      7'b1111001: decode = {1'b1, 4'hE};
      7'b1110001: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  // Run counter next state and capture strobe. A mismatch restarts the run
  // at 1, which itself counts as reaching the target when STABLE_CYCLES=1.
  always_comb begin
    match = (sync2_q == s_q);
    if (!match)
      cnt_d = CNT_ONE;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_ONE;
    capture = (cnt_d == CNT_MAX) && (!match || (cnt_q != CNT_MAX));
  end

  // Capture action: update only the digit selected by the captured sample.
  always_comb begin
    digit0_d  = digit0_q;
    digit1_d  = digit1_q;
    valid_d   = valid_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    upd_sel_d = upd_sel_q;
    cap_sel   = sync2_q[7];
    cap_seg   = sync2_q[6:0];
    dec       = decode(cap_seg);
    if (capture) begin
      upd_sel_d = cap_sel;
      if (dec[4]) begin
        if (cap_sel) digit1_d = dec[3:0];
        else         digit0_d = dec[3:0];
        valid_d[cap_sel] = 1'b1;
        err_d[cap_sel]   = 1'b0;
        upd_d            = 1'b1;
      end else if (cap_seg == 7'b0000000) begin
        valid_d[cap_sel] = 1'b0;
        err_d[cap_sel]   = 1'b0;
      end else begin
        err_d[cap_sel]   = 1'b1;
      end
    end
  end

  // Synchronizer, sample register, run counter and output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      digit0_q  <= '0;
      digit1_q  <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_sel_q <= 1'b0;
    end else begin
      sync1_q   <= {bus.dig_sel, bus.seg};
      sync2_q   <= sync1_q;
      s_q       <= sync2_q;
      cnt_q     <= cnt_d;
      digit0_q  <= digit0_d;
      digit1_q  <= digit1_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_sel_q <= upd_sel_d;
    end
  end

  assign bus.digit0  = digit0_q;
  assign bus.digit1  = digit1_q;
  assign bus.valid   = valid_q;
  assign bus.err     = err_q;
  assign bus.upd     = upd_q;
  assign bus.upd_sel = upd_sel_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed table, multi-cycle
// corner sequences and randomized traffic against a run-length model.
module tb_seven_seg_capture;
  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seven_seg_capture_if bus ();
  seven_seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;

  logic [6:0] PAT [16];

  // Reference model: two-sample input delay, unbounded run length.
  logic [7:0] m_pipe [2];
  logic [7:0] m_prev;
  int         m_run;
  logic [3:0] m_dig [2];
  logic [1:0] m_valid, m_err;
  logic       m_upd, m_upd_sel;

  typedef struct {
    logic       sel;
    logic [6:0] seg;
    logic [3:0] exp_dig;
    logic       exp_valid;
    logic       exp_err;
    int         exp_upd;
  } vec_t;
  vec_t vecs [37];

  task automatic model_reset();
    m_pipe[0] = '0; m_pipe[1] = '0; m_prev = '0; m_run = 0;
    m_dig[0] = '0; m_dig[1] = '0; m_valid = '0; m_err = '0;
    m_upd = 1'b0; m_upd_sel = 1'b0;
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (PAT[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [7:0] cmp;
    int         n;
    logic       sel;
    if (rst) begin
      model_reset();
      return;
    end
    cmp = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = {bus.dig_sel, bus.seg};
    m_upd = 1'b0;
    if (cmp == m_prev) m_run++;
    else               m_run = 1;
    m_prev = cmp;
    if (m_run == int'(STABLE)) begin
      sel = cmp[7];
      n = lookup(cmp[6:0]);
      m_upd_sel = sel;
      if (n >= 0) begin
        m_dig[sel]   = 4'(n);
        m_valid[sel] = 1'b1;
        m_err[sel]   = 1'b0;
        m_upd        = 1'b1;
      end else if (cmp[6:0] == 7'd0) begin
        m_valid[sel] = 1'b0;
        m_err[sel]   = 1'b0;
      end else begin
        m_err[sel]   = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [13:0] act, exp;
    act = {bus.digit0, bus.digit1, bus.valid, bus.err, bus.upd, bus.upd_sel};
    exp = {m_dig[0], m_dig[1], m_valid, m_err, m_upd, m_upd_sel};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model_cmp: got %h expected %h at %0t", act, exp, $time);
    end
  endtask

  // One clock: model advances with the DUT, outputs checked #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    if (bus.upd) upd_seen++;
    @(negedge clk);
  endtask

  task automatic apply(input logic sel, input logic [6:0] seg, input int n);
    bus.dig_sel = sel;
    bus.seg     = seg;
    repeat (n) step();
  endtask

  initial begin
    int first;
    PAT[0]  = 7'b0111111; PAT[1]  = 7'b0000110; PAT[2]  = 7'b1011011; PAT[3]  = 7'b1001111;
    PAT[4]  = 7'b1100110; PAT[5]  = 7'b1101101; PAT[6]  = 7'b1111101; PAT[7]  = 7'b0000111;
    PAT[8]  = 7'b1111111; PAT[9]  = 7'b1101111; PAT[10] = 7'b1110111; PAT[11] = 7'b1111100;
    PAT[12] = 7'b0111001; PAT[13] = 7'b1011110; PAT[14] = 7'b1111001; PAT[15] = 7'b1110001;

    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{1'b0, PAT[i], 4'(i), 1'b1, 1'b0, 1};
      vecs[16 + i] = '{1'b1, PAT[i], 4'(i), 1'b1, 1'b0, 1};
    end
    vecs[32] = '{1'b0, 7'b1101101, 4'h5, 1'b1, 1'b0, 1};
    vecs[33] = '{1'b0, 7'b1000000, 4'h5, 1'b1, 1'b1, 0};
    vecs[34] = '{1'b0, 7'b0000111, 4'h7, 1'b1, 1'b0, 1};
    vecs[35] = '{1'b1, 7'b1110111, 4'hA, 1'b1, 1'b0, 1};
    vecs[36] = '{1'b1, 7'b0000000, 4'hA, 1'b0, 1'b0, 0};

    // Reset state.
    bus.dig_sel = 1'b0;
    bus.seg     = '0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("reset_outputs",
        int'({bus.digit0, bus.digit1, bus.valid, bus.err, bus.upd, bus.upd_sel}), 0);
    step();
    rst = 1'b0;

    // Held digit0=3: single upd exactly on the sixth edge after presentation.
    upd_seen = 0;
    apply(1'b0, 7'b1001111, 5);
    chk("hold3_no_early_upd", upd_seen, 0);
    step();
    chk("hold3_upd", int'(bus.upd), 1);
    chk("hold3_digit0", int'(bus.digit0), 3);
    chk("hold3_valid", int'(bus.valid), 1);
    chk("hold3_err", int'(bus.err), 0);
    repeat (10) step();
    chk("hold3_single_pulse", upd_seen, 1);

    // Table of patterns, each held long enough for one capture.
    for (int i = 0; i < 37; i++) begin
      upd_seen = 0;
      apply(vecs[i].sel, vecs[i].seg, 10);
      chk($sformatf("vec%0d_digit", i),
          int'(vecs[i].sel ? bus.digit1 : bus.digit0), int'(vecs[i].exp_dig));
      chk($sformatf("vec%0d_valid", i), int'(bus.valid[vecs[i].sel]), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_err", i), int'(bus.err[vecs[i].sel]), int'(vecs[i].exp_err));
      chk($sformatf("vec%0d_upd", i), upd_seen, vecs[i].exp_upd);
      chk($sformatf("vec%0d_upd_sel", i), int'(bus.upd_sel), int'(vecs[i].sel));
    end

    // Short glitch inside a held digit1=0 is ignored; the restored run recaptures.
    apply(1'b1, 7'b0111111, 10);
    upd_seen = 0;
    apply(1'b1, 7'b0000110, 3);
    apply(1'b1, 7'b0111111, 3);
    chk("glitch_no_upd", upd_seen, 0);
    chk("glitch_digit1", int'(bus.digit1), 0);
    apply(1'b1, 7'b0111111, 7);
    chk("glitch_recapture_upd", upd_seen, 1);
    chk("glitch_recapture_digit1", int'(bus.digit1), 0);

    // Two-digit scan with 8-cycle slots.
    for (int s = 0; s < 3; s++) begin
      upd_seen = 0;
      apply(1'b0, 7'b1111111, 8);
      chk("scan_upd_sel0", int'(bus.upd_sel), 0);
      apply(1'b1, 7'b1110001, 8);
      chk("scan_upd_sel1", int'(bus.upd_sel), 1);
      chk("scan_upd_count", upd_seen, 2);
    end
    chk("scan_digits", int'({bus.digit0, bus.digit1, bus.valid}), int'({4'h8, 4'hF, 2'b11}));

    // Reset mid-run with two stable samples counted on digit0=9.
    apply(1'b0, 7'b1101111, 4);
    rst = 1'b1;
    #1;
    chk("midrst_outputs",
        int'({bus.digit0, bus.digit1, bus.valid, bus.err, bus.upd, bus.upd_sel}), 0);
    step();
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.upd && first == 0) first = k;
    end
    chk("midrst_capture_edge", first, int'(STABLE) + 2);
    chk("midrst_digit0", int'(bus.digit0), 9);

    // Randomized traffic against the model.
    for (int r = 0; r < 400; r++) begin
      logic [6:0] p;
      if ($urandom_range(3) != 0) p = PAT[$urandom_range(15)];
      else if ($urandom_range(3) == 0) p = 7'd0;
      else p = 7'($urandom);
      apply(1'($urandom), p, int'($urandom_range(8, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
